demux_channel_sequencer: RTL

//  Upstream sequencer for the 1-to-8 demux: accepts a serial bit stream with valid/ready and

---
 rtl/demux_channel_sequencer_if.sv | 28 ++
 rtl/demux_channel_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/demux_channel_sequencer_if.sv
// Handshake and beat bus between the serial upstream, the channel sequencer and the 1-to-8 demux.
// The master side drives the input stream and out_ready; the slave side is the sequencer.
interface demux_channel_sequencer_if #(
    parameter int NCH = 8,
    parameter int SW  = 3
);
    logic [NCH-1:0] en_mask;
    logic           in_valid;
    logic           in_data;
    logic           in_sof;
    logic           in_ready;
    logic           out_ready;
    logic [SW-1:0]  s;
    logic           a;
    logic           out_valid;
    logic           frame_done;
    logic           frame_abort;

    modport master (
        output en_mask, in_valid, in_data, in_sof, out_ready,
        input  in_ready, s, a, out_valid, frame_done, frame_abort
    );

    modport slave (
        input  en_mask, in_valid, in_data, in_sof, out_ready,
        output in_ready, s, a, out_valid, frame_done, frame_abort
    );
endinterface

// File: rtl/demux_channel_sequencer.sv
// Routes each accepted serial bit to the next enabled demux channel in ascending order,
// with one registered output beat (s, a, frame_done) and a frame_abort pulse on early sof.
module demux_channel_sequencer #(
    parameter int NCH = 8,
    parameter int SW  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    demux_channel_sequencer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [SW-1:0]  ptr_q, ptr_d;
    logic [SW-1:0]  s_q, s_d;
    logic           a_q, a_d;
    logic           vld_q, vld_d;
    logic           done_q, done_d;
    logic           abort_q, abort_d;
    logic           accept;
    logic           load;
    logic [SW-1:0]  ch;
    logic [SW-1:0]  last_ch;

    function automatic logic [SW-1:0] lowest_set(input logic [NCH-1:0] m);
        lowest_set = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = i[SW-1:0];
        end
    endfunction

    function automatic logic [SW-1:0] highest_set(input logic [NCH-1:0] m);
        highest_set = '0;
        for (int i = 0; i < NCH; i++) begin
            if (m[i]) highest_set = i[SW-1:0];
        end
    endfunction

    // Strictly above the pointer, no wrap: a frame only ever walks upward.
    function automatic logic [SW-1:0] next_above(input logic [NCH-1:0] m, input logic [SW-1:0] p);
        next_above = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(p))) next_above = i[SW-1:0];
        end
    endfunction

    assign bus.in_ready = !vld_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        s_d     = s_q;
        a_d     = a_q;
        vld_d   = vld_q;
        done_d  = done_q;
        abort_d = 1'b0;
        load    = 1'b0;
        ch      = '0;
        last_ch = '0;

        if (bus.out_ready || accept) begin
            vld_d  = 1'b0;
            a_d    = 1'b0;
            done_d = 1'b0;
        end

        if (accept) begin
            if (bus.in_sof) begin
                abort_d = (state_q == RUN);
                mask_d  = bus.en_mask;
                state_d = IDLE;
                if (bus.en_mask != '0) begin
                    load    = 1'b1;
                    ch      = lowest_set(bus.en_mask);
                    last_ch = highest_set(bus.en_mask);
                end
            end else if (state_q == RUN) begin
                load    = 1'b1;
                ch      = next_above(mask_q, ptr_q);
                last_ch = highest_set(mask_q);
            end
        end

        if (load) begin
            s_d     = ch;
            a_d     = bus.in_data;
            vld_d   = 1'b1;
            done_d  = (ch == last_ch);
            ptr_d   = ch;
            state_d = (ch == last_ch) ? IDLE : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ptr_q   <= '0;
            s_q     <= '0;
            a_q     <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            a_q     <= a_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign bus.s           = s_q;
    assign bus.a           = a_q;
    assign bus.out_valid   = vld_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_abort = abort_q;
endmodule
